// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, immediate formats, fetch states and
// the decoded-instruction payload handed from fetch/decode to execute.
package riscv_pkg;

    localparam int unsigned XLEN_W   = 32;
    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned REG_W    = 5;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } imm_fmt_e;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_REQ  = 2'd1,
        FS_WAIT = 2'd2,
        FS_HOLD = 2'd3
    } fetch_state_e;

    // Decoded instruction as presented to execute
    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [6:0]          funct7;
        logic [2:0]          funct3;
        logic [REG_W-1:0]    rs1;
        logic [REG_W-1:0]    rs2;
        logic [REG_W-1:0]    rd;
        logic [XLEN_W-1:0]   imm;
        logic                illegal;
    } dec_instr_t;

endpackage

// File: rtl/riscv_imm_gen.sv
// Combinational immediate generator.
// Ports: i_instr (32b word) -> o_fmt_c (format), o_imm_c (sign-extended
// immediate), o_illegal_c (opcode outside the RV32I base set).
module riscv_imm_gen
    import riscv_pkg::*;
(
    input  logic [31:0] i_instr,
    output imm_fmt_e    o_fmt_c,
    output logic [31:0] o_imm_c,
    output logic        o_illegal_c
);

    // Opcode -> immediate format classification
    always_comb begin
        o_fmt_c     = FMT_R;
        o_illegal_c = 1'b0;
        case (i_instr[6:0])
            OP_LUI, OP_AUIPC:                     o_fmt_c = FMT_U;
            OP_JAL:                               o_fmt_c = FMT_J;
            OP_JALR, OP_LOAD, OP_IMM,
            OP_SYSTEM, OP_FENCE:                  o_fmt_c = FMT_I;
            OP_BRANCH:                            o_fmt_c = FMT_B;
            OP_STORE:                             o_fmt_c = FMT_S;
            OP_REG:                               o_fmt_c = FMT_R;
            default:                              o_illegal_c = 1'b1;
        endcase
    end

    // Immediate assembly per format; R-type and unknown opcodes yield zero
    always_comb begin
        o_imm_c = '0;
        case (o_fmt_c)
            FMT_I: o_imm_c = {{20{i_instr[31]}}, i_instr[31:20]};
            FMT_S: o_imm_c = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            FMT_B: o_imm_c = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                              i_instr[30:25], i_instr[11:8], 1'b0};
            FMT_U: o_imm_c = {i_instr[31:12], 12'b0};
            FMT_J: o_imm_c = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                              i_instr[20], i_instr[30:21], 1'b0};
            default: o_imm_c = '0;
        endcase
    end

endmodule

// File: rtl/riscv_fetch_decode.sv
// RV32I fetch/decode front end: owns the PC, issues one fetch at a time on a
// req/gnt/rvalid port, decodes the returned word and presents it to execute
// on a valid/ready handshake. A redirect from execute retargets the PC and
// discards whatever is in flight or held.
// Ports: i_clk/i_rst_n; o_imem_req/o_imem_addr/i_imem_gnt/i_imem_rvalid/
// i_imem_rdata (instruction memory); i_redirect/i_redirect_pc (branch
// target); o_valid/i_ready plus o_opcode, o_funct7, o_funct3, o_rs1, o_rs2,
// o_rd, o_imm_num, o_pc, o_illegal (decoded instruction).
module riscv_fetch_decode
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned XLEN     = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_gnt,
    input  logic            i_imem_rvalid,
    input  logic [XLEN-1:0] i_imem_rdata,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [6:0]      o_opcode,
    output logic [6:0]      o_funct7,
    output logic [2:0]      o_funct3,
    output logic [4:0]      o_rs1,
    output logic [4:0]      o_rs2,
    output logic [4:0]      o_rd,
    output logic [XLEN-1:0] o_imm_num,
    output logic [XLEN-1:0] o_pc,
    output logic            o_illegal
);

    localparam logic [1:0] ST_IDLE = 2'(FS_IDLE);
    localparam logic [1:0] ST_REQ  = 2'(FS_REQ);
    localparam logic [1:0] ST_WAIT = 2'(FS_WAIT);
    localparam logic [1:0] ST_HOLD = 2'(FS_HOLD);

    localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

    logic [1:0]  r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;          // next PC to fetch
    logic [31:0] r_addr, w_addr_nxt;      // address on the memory port
    logic        r_req, w_req_nxt;
    logic        r_drop, w_drop_nxt;      // next response belongs to a squashed fetch
    logic        r_valid, w_valid_nxt;
    logic [31:0] r_inst_pc, w_inst_pc_nxt;
    dec_instr_t  r_dec, w_dec_nxt, w_dec;
    logic        w_capture;

    imm_fmt_e    w_fmt;
    logic [31:0] w_imm;
    logic        w_illegal;
    logic [31:0] w_redirect_pc;
    logic        w_unused_bits;

    assign w_redirect_pc = {i_redirect_pc[31:2], 2'b00};
    assign w_unused_bits = ^i_redirect_pc[1:0];

    riscv_imm_gen u_imm_gen (
        .i_instr     (i_imem_rdata),
        .o_fmt_c     (w_fmt),
        .o_imm_c     (w_imm),
        .o_illegal_c (w_illegal)
    );

    // Decode of the word currently on the read-data bus
    always_comb begin
        w_dec         = '0;
        w_dec.opcode  = i_imem_rdata[6:0];
        w_dec.funct7  = i_imem_rdata[31:25];
        w_dec.funct3  = i_imem_rdata[14:12];
        w_dec.rs1     = i_imem_rdata[19:15];
        w_dec.rs2     = i_imem_rdata[24:20];
        w_dec.rd      = i_imem_rdata[11:7];
        w_dec.imm     = (w_fmt == FMT_R) ? '0 : w_imm;
        w_dec.illegal = w_illegal;
    end

    // Next-state and registered-output logic; redirect overrides everything
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_addr_nxt  = r_addr;
        w_req_nxt   = r_req;
        w_drop_nxt  = r_drop;
        w_valid_nxt = r_valid;
        w_capture   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_REQ;
                w_req_nxt   = 1'b1;
                w_addr_nxt  = r_pc;
            end
            ST_REQ: begin
                if (i_imem_gnt) begin
                    w_state_nxt = ST_WAIT;
                    w_req_nxt   = 1'b0;
                end
            end
            ST_WAIT: begin
                if (i_imem_rvalid) begin
                    if (r_drop) begin
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = ST_REQ;
                        w_req_nxt   = 1'b1;
                        w_addr_nxt  = r_pc;
                    end else begin
                        w_capture   = 1'b1;
                        w_valid_nxt = 1'b1;
                        w_pc_nxt    = r_addr + 32'd4;
                        w_state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (i_ready) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = ST_REQ;
                    w_req_nxt   = 1'b1;
                    w_addr_nxt  = r_pc;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_req_nxt   = 1'b0;
            end
        endcase

        if (i_redirect) begin
            w_pc_nxt    = w_redirect_pc;
            w_valid_nxt = 1'b0;
            w_capture   = 1'b0;
            case (r_state)
                ST_REQ: begin
                    // Address must stay put until granted; squash its response instead
                    w_drop_nxt = 1'b1;
                end
                ST_WAIT: begin
                    if (i_imem_rvalid) begin
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = ST_REQ;
                        w_req_nxt   = 1'b1;
                        w_addr_nxt  = w_redirect_pc;
                    end else begin
                        w_drop_nxt  = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_REQ;
                    w_req_nxt   = 1'b1;
                    w_addr_nxt  = w_redirect_pc;
                end
            endcase
        end

        w_dec_nxt     = w_capture ? w_dec : r_dec;
        w_inst_pc_nxt = w_capture ? r_addr : r_inst_pc;
    end

    // State and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_pc      <= RESET_PC_AL;
            r_addr    <= RESET_PC_AL;
            r_req     <= 1'b0;
            r_drop    <= 1'b0;
            r_valid   <= 1'b0;
            r_inst_pc <= '0;
            r_dec     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_addr    <= w_addr_nxt;
            r_req     <= w_req_nxt;
            r_drop    <= w_drop_nxt;
            r_valid   <= w_valid_nxt;
            r_inst_pc <= w_inst_pc_nxt;
            r_dec     <= w_dec_nxt;
        end
    end

    assign o_imem_req  = r_req;
    assign o_imem_addr = r_addr;
    assign o_valid     = r_valid;
    assign o_opcode    = r_dec.opcode;
    assign o_funct7    = r_dec.funct7;
    assign o_funct3    = r_dec.funct3;
    assign o_rs1       = r_dec.rs1;
    assign o_rs2       = r_dec.rs2;
    assign o_rd        = r_dec.rd;
    assign o_imm_num   = r_dec.imm;
    assign o_pc        = r_inst_pc;
    assign o_illegal   = r_dec.illegal;

endmodule

// File: tb/tb_riscv_fetch_decode.sv
// Bench for riscv_fetch_decode: memory responder with random grant/latency,
// a PC-sequence reference model and an arithmetic decode model.
`timescale 1ns/1ps
module tb_riscv_fetch_decode;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        valid;
    logic        ready;
    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm_num;
    logic [31:0] pc;
    logic        illegal;

    riscv_fetch_decode #(.RESET_PC(RST_PC), .XLEN(32)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .o_imem_req    (imem_req),
        .o_imem_addr   (imem_addr),
        .i_imem_gnt    (imem_gnt),
        .i_imem_rvalid (imem_rvalid),
        .i_imem_rdata  (imem_rdata),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_valid       (valid),
        .i_ready       (ready),
        .o_opcode      (opcode),
        .o_funct7      (funct7),
        .o_funct3      (funct3),
        .o_rs1         (rs1),
        .o_rs2         (rs2),
        .o_rd          (rd),
        .o_imm_num     (imm_num),
        .o_pc          (pc),
        .o_illegal     (illegal)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int npres  = 0;

    logic [64:0] dut_dec;
    assign dut_dec = {opcode, funct7, funct3, rs1, rs2, rd, imm_num, illegal};

    // Values seen by the DUT at the last rising edge
    logic s_req = 1'b0, s_gnt = 1'b0;
    logic [31:0] s_addr = '0;
    always @(posedge clk) begin
        s_req  <= imem_req;
        s_gnt  <= imem_gnt;
        s_addr <= imem_addr;
    end

    // Instruction memory contents and responder knobs
    logic [31:0] mem [256];
    int gnt_pct  = 100;
    int lat_min  = 0;
    int lat_max  = 0;
    bit withhold = 1'b0;

    // Reference model state
    logic [31:0] model_pc;
    logic        pv_valid;
    logic [31:0] pv_pc;
    logic [64:0] pv_dec;

    function automatic logic [64:0] ref_dec(input logic [31:0] w);
        logic [31:0] s;
        logic [31:0] imm;
        logic        ill;
        s   = {32{w[31]}};
        imm = 32'h0;
        ill = 1'b0;
        case (w[6:0])
            7'b0110111, 7'b0010111: imm = w & 32'hFFFF_F000;
            7'b1101111: imm = (s << 20) | (w & 32'h000F_F000) | ((w >> 9) & 32'h800) | ((w >> 20) & 32'h7FE);
            7'b1100111, 7'b0000011, 7'b0010011, 7'b1110011, 7'b0001111: imm = 32'($signed(w) >>> 20);
            7'b1100011: imm = (s << 12) | ((w << 4) & 32'h800) | ((w >> 20) & 32'h7E0) | ((w >> 7) & 32'h1E);
            7'b0100011: imm = (s << 11) | ((w >> 20) & 32'h7E0) | ((w >> 7) & 32'h1F);
            7'b0110011: imm = 32'h0;
            default:    ill = 1'b1;
        endcase
        return {w[6:0], w[31:25], w[14:12], w[19:15], w[24:20], w[11:7], imm, ill};
    endfunction

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory responder: one outstanding fetch, random grant and latency
    initial begin : memory
        bit          pending;
        int          wcnt;
        logic [31:0] raddr;
        pending     = 1'b0;
        wcnt        = 0;
        raddr       = '0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pending     = 1'b0;
                imem_gnt    = 1'b0;
                imem_rvalid = 1'b0;
            end else begin
                if (imem_rvalid) pending = 1'b0;
                if (s_req && s_gnt) begin
                    pending = 1'b1;
                    raddr   = s_addr;
                    wcnt    = $urandom_range(lat_max, lat_min);
                end
                imem_rvalid = 1'b0;
                imem_rdata  = $urandom();
                if (pending) begin
                    if (wcnt == 0) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = mem[raddr[9:2]];
                    end else begin
                        wcnt--;
                    end
                end
                imem_gnt = imem_req && !pending && !withhold &&
                           (int'($urandom_range(99, 0)) < gnt_pct);
            end
        end
    end

    // Per-cycle protocol and model checks, run at the falling edge
    task automatic monitor();
        if (!rst_n) begin
            pv_valid = 1'b0;
            return;
        end
        if (pv_valid && (ready || redirect)) begin
            check("accept_or_redirect_drops_valid", valid, 1'b0);
        end else if (pv_valid) begin
            check("hold_stable", {valid, pc, dut_dec}, {1'b1, pv_pc, pv_dec});
        end else if (valid) begin
            check("pres_pc", pc, model_pc);
            check("pres_decode", dut_dec, ref_dec(mem[model_pc[9:2]]));
            model_pc = model_pc + 32'd4;
            npres++;
        end else if (redirect) begin
            check("redirect_valid_low", valid, 1'b0);
        end
        if (valid)
            check("no_req_while_valid", imem_req, 1'b0);
        if (s_req && !s_gnt)
            check("addr_hold", {imem_req, imem_addr}, {1'b1, s_addr});
        if (imem_req && !s_req)
            check("addr_align", imem_addr[1:0], 2'b00);
        pv_valid = valid;
        pv_pc    = pc;
        pv_dec   = dut_dec;
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!valid && n < 50) begin cycle(); n++; end
        check(tag, valid, 1'b1);
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!imem_req && n < 50) begin cycle(); n++; end
        check(tag, imem_req, 1'b1);
    endtask

    task automatic wait_noreq(input string tag);
        int n = 0;
        while (imem_req && n < 50) begin cycle(); n++; end
        check(tag, imem_req, 1'b0);
    endtask

    task automatic wait_handshake(input string tag);
        int n = 0;
        while (!(s_req && s_gnt) && n < 50) begin cycle(); n++; end
        check(tag, s_req && s_gnt, 1'b1);
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect    = 1'b1;
        redirect_pc = target;
        model_pc    = target & 32'hFFFF_FFFC;
        cycle();
        redirect    = 1'b0;
    endtask

    task automatic accept();
        ready = 1'b1;
        cycle();
        ready = 1'b0;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [6:0] ops [12];
        logic [31:0] w;
        ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
                7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111, 7'b1110011, 7'b0000000};
        for (int i = 0; i < 256; i++) begin
            w = $urandom();
            if ($urandom_range(3, 0) != 0) w[6:0] = ops[$urandom_range(11, 0)];
            mem[i] = w;
        end
        mem[0]   = 32'h0050_0093;
        mem[1]   = 32'hFFF0_0093;
        mem[2]   = 32'h1234_5137;
        mem[255] = 32'h0000_007F;

        rst_n       = 1'b0;
        ready       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        pv_valid    = 1'b0;
        pv_pc       = '0;
        pv_dec      = '0;
        model_pc    = RST_PC;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_valid", valid, 1'b0);
        check("rst_req", imem_req, 1'b0);
        check("rst_pc", pc, 32'h0);
        check("rst_decode", dut_dec, 65'h0);
        rst_n = 1'b1;

        // First fetch: ADDI x1,x0,5
        wait_req("t1_req");
        check("t1_addr", imem_addr, RST_PC);
        wait_valid("t1_valid");
        check("t1_fields", {opcode, rd, rs1, funct3, imm_num, pc},
                           {7'h13, 5'd1, 5'd0, 3'd0, 32'd5, RST_PC});
        accept();
        wait_req("t1_next_req");
        check("t1_next_addr", imem_addr, RST_PC + 32'd4);

        // Negative I immediate and LUI
        wait_valid("t2_valid_a");
        check("t2_addi_imm", imm_num, 32'hFFFF_FFFF);
        accept();
        wait_valid("t2_valid_b");
        check("t2_lui", {imm_num, rd}, {32'h1234_5000, 5'd2});

        // Execute stalls for five cycles
        repeat (5) cycle();
        check("t3_still_valid", {valid, imem_req}, {1'b1, 1'b0});
        accept();
        wait_req("t3_req");
        check("t3_addr", imem_addr, 32'h0000_000C);

        // Redirect while waiting for data: stale word must never appear
        mem[3]  = 32'hDEAD_BEEF;
        lat_min = 2;
        lat_max = 2;
        wait_handshake("t4_hs");
        do_redirect(32'h0000_0100);
        lat_min = 0;
        lat_max = 0;
        wait_req("t4_req");
        check("t4_addr", imem_addr, 32'h0000_0100);
        wait_valid("t4_valid");
        check("t4_pc", pc, 32'h0000_0100);

        // Redirect in REQ with grant withheld
        withhold = 1'b1;
        accept();
        wait_req("t5_req");
        check("t5_addr", imem_addr, 32'h0000_0104);
        do_redirect(32'h0000_0200);
        repeat (2) cycle();
        check("t5_addr_held", {imem_req, imem_addr}, {1'b1, 32'h0000_0104});
        withhold = 1'b0;
        wait_noreq("t5_granted");
        wait_req("t5_refetch");
        check("t5_target_addr", imem_addr, 32'h0000_0200);
        wait_valid("t5_valid");
        check("t5_pc", pc, 32'h0000_0200);
        ready = 1'b1;
        do_redirect(32'h0000_0300);
        ready = 1'b0;
        check("t5_redir_accept", valid, 1'b0);
        wait_req("t5_req2");
        check("t5_addr2", imem_addr, 32'h0000_0300);

        // PC wrap and illegal opcode
        wait_valid("t6_valid_a");
        ready = 1'b1;
        do_redirect(32'hFFFF_FFFE);
        ready = 1'b0;
        wait_valid("t6_valid_b");
        check("t6_illegal", {illegal, imm_num, opcode, pc}, {1'b1, 32'h0, 7'h7F, 32'hFFFF_FFFC});
        accept();
        wait_req("t6_req");
        check("t6_wrap_addr", imem_addr, 32'h0000_0000);

        // Randomized traffic
        gnt_pct = 60;
        lat_min = 0;
        lat_max = 2;
        npres   = 0;
        for (int i = 0; i < 2000; i++) begin
            ready = (int'($urandom_range(99, 0)) < 70);
            if ($urandom_range(99, 0) < 4)
                do_redirect($urandom() & 32'h0000_03FF);
            else
                cycle();
        end
        ready = 1'b0;
        check("rand_progress", npres > 100, 1'b1);

        // Asynchronous reset in the middle of a fetch
        gnt_pct = 100;
        lat_min = 1;
        lat_max = 1;
        wait_handshake("arst_hs");
        #2 rst_n = 1'b0;
        #1;
        check("arst_outputs", {valid, imem_req, pc, dut_dec}, {1'b0, 1'b0, 32'h0, 65'h0});
        @(negedge clk);
        @(negedge clk);
        pv_valid = 1'b0;
        model_pc = RST_PC;
        lat_min  = 0;
        lat_max  = 0;
        rst_n    = 1'b1;
        wait_valid("arst_refetch");
        check("arst_pc", pc, RST_PC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
